// File: rtl/wta_inhibit.sv
// k-winner-take-all lateral inhibition over race-logic spike lines within one gamma cycle.
// Passes the first K rising edges to out_o and records the first winner's index and arrival time.
module wta_inhibit #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int WIDTH             = 8,
    parameter int K                 = 1,
    localparam int TW = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             aclk_i,
    input  logic             rst_i,
    input  logic             grst_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o,
    output logic             winner_valid_o,
    output logic [IW-1:0]    winner_idx_o,
    output logic [TW-1:0]    winner_time_o
);

    localparam int CW = $clog2(K + 1);
    localparam logic [TW-1:0] TMAX  = TW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [CW-1:0] K_CNT = CW'(K);

    generate
        if (K < 1 || K > WIDTH) begin : g_bad_k
            $error("wta_inhibit: K must be in 1..WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {WAIT_GRST, ACTIVE, INHIBIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] in_prev_q;
    logic             valid_q, valid_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [TW-1:0]    time_q, time_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [CW-1:0]    win_cnt_q, win_cnt_d;

    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] grant;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    first_idx;
    logic             found;

    // Lowest-index edges win, up to the remaining winner budget; the rest are dropped.
    always_comb begin
        edges     = '0;
        grant     = '0;
        cnt       = win_cnt_q;
        first_idx = '0;
        found     = 1'b0;
        if (state_q == ACTIVE && !grst_i)
            edges = in_i & ~in_prev_q & ~out_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (edges[i] && cnt < K_CNT) begin
                grant[i] = 1'b1;
                cnt      = cnt + CW'(1);
                if (!found) begin
                    found     = 1'b1;
                    first_idx = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge aclk_i) begin
        if (rst_i) state_q <= WAIT_GRST;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (grst_i)
            state_d = ACTIVE;
        else if (state_q == ACTIVE && cnt == K_CNT)
            state_d = INHIBIT;
    end

    always_comb begin
        out_d     = out_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        time_d    = time_q;
        win_cnt_d = win_cnt_q;
        tcnt_d    = tcnt_q;
        if (grst_i) begin
            out_d     = '0;
            valid_d   = 1'b0;
            idx_d     = '0;
            time_d    = '0;
            win_cnt_d = '0;
            tcnt_d    = '0;
        end else begin
            if (state_q != WAIT_GRST && tcnt_q != TMAX)
                tcnt_d = tcnt_q + TW'(1);
            if (state_q == ACTIVE) begin
                out_d     = out_q | grant;
                win_cnt_d = cnt;
                if (win_cnt_q == '0 && found) begin
                    valid_d = 1'b1;
                    idx_d   = first_idx;
                    time_d  = tcnt_q;
                end
            end
        end
    end

    always_ff @(posedge aclk_i) begin
        if (rst_i) begin
            out_q     <= '0;
            in_prev_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            time_q    <= '0;
            tcnt_q    <= '0;
            win_cnt_q <= '0;
        end else begin
            out_q     <= out_d;
            in_prev_q <= in_i;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            time_q    <= time_d;
            tcnt_q    <= tcnt_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    assign out_o          = out_q;
    assign winner_valid_o = valid_q;
    assign winner_idx_o   = idx_q;
    assign winner_time_o  = time_q;

endmodule

// File: tb/tb_wta_inhibit.sv
// Directed bench for wta_inhibit: a K=1 and a K=2 instance share stimulus, each row
// carries hand-computed expectations for both.
module tb_wta_inhibit;

    logic       aclk = 1'b0;
    logic       rst  = 1'b1;
    logic       grst = 1'b0;
    logic [7:0] in_v = 8'h00;

    logic [7:0] out1, out2;
    logic       v1, v2;
    logic [2:0] idx1, idx2;
    logic [3:0] tm1, tm2;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    wta_inhibit #(.GAMMA_CYCLE_WIDTH(16), .WIDTH(8), .K(1)) u_k1 (
        .aclk_i(aclk), .rst_i(rst), .grst_i(grst), .in_i(in_v),
        .out_o(out1), .winner_valid_o(v1), .winner_idx_o(idx1), .winner_time_o(tm1)
    );

    wta_inhibit #(.GAMMA_CYCLE_WIDTH(16), .WIDTH(8), .K(2)) u_k2 (
        .aclk_i(aclk), .rst_i(rst), .grst_i(grst), .in_i(in_v),
        .out_o(out2), .winner_valid_o(v2), .winner_idx_o(idx2), .winner_time_o(tm2)
    );

    typedef struct {
        logic       rst;
        logic       grst;
        logic [7:0] in;
        logic [7:0] o1; logic v1; logic [2:0] i1; logic [3:0] t1;
        logic [7:0] o2; logic v2; logic [2:0] i2; logic [3:0] t2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic g, input logic [7:0] i,
                                input logic [7:0] o1, input logic v1, input logic [2:0] i1, input logic [3:0] t1,
                                input logic [7:0] o2, input logic v2, input logic [2:0] i2, input logic [3:0] t2);
        vec_t v;
        v.rst = r; v.grst = g; v.in = i;
        v.o1 = o1; v.v1 = v1; v.i1 = i1; v.t1 = t1;
        v.o2 = o2; v.v2 = v2; v.i2 = i2; v.t2 = t2;
        return v;
    endfunction

    function automatic vec_t zr(input logic r, input logic g, input logic [7:0] i);
        return mk(r, g, i, 8'h00, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 3'd0, 4'd0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_all(input string tag,
                           input logic [7:0] o1, input logic ev1, input logic [2:0] i1, input logic [3:0] t1,
                           input logic [7:0] o2, input logic ev2, input logic [2:0] i2, input logic [3:0] t2);
        chk({tag, " k1.out"},   32'(out1), 32'(o1));
        chk({tag, " k1.valid"}, 32'(v1),   32'(ev1));
        chk({tag, " k1.idx"},   32'(idx1), 32'(i1));
        chk({tag, " k1.time"},  32'(tm1),  32'(t1));
        chk({tag, " k2.out"},   32'(out2), 32'(o2));
        chk({tag, " k2.valid"}, 32'(v2),   32'(ev2));
        chk({tag, " k2.idx"},   32'(idx2), 32'(i2));
        chk({tag, " k2.time"},  32'(tm2),  32'(t2));
    endtask

    initial begin
        // Test 1: spikes before the first grst are ignored.
        rst = 1'b1; tick();
        chk_all("reset", 8'h00, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 3'd0, 4'd0);
        rst = 1'b0; in_v = 8'h20;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk_all("pre_grst", 8'h00, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 3'd0, 4'd0);
        end
        in_v = 8'h00; tick();

        // Test 2: in[2] at t=1, in[5] at t=2.
        vecs.push_back(zr(0, 1, 8'h00));
        vecs.push_back(zr(0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h04, 8'h04, 1, 3'd2, 4'd1, 8'h04, 1, 3'd2, 4'd1));
        vecs.push_back(mk(0, 0, 8'h24, 8'h04, 1, 3'd2, 4'd1, 8'h24, 1, 3'd2, 4'd1));
        vecs.push_back(mk(0, 0, 8'h24, 8'h04, 1, 3'd2, 4'd1, 8'h24, 1, 3'd2, 4'd1));
        // Test 3: tie between in[6] and in[3] at t=4.
        vecs.push_back(zr(0, 1, 8'h24));
        for (int n = 0; n < 4; n++) vecs.push_back(zr(0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h48, 8'h08, 1, 3'd3, 4'd4, 8'h48, 1, 3'd3, 4'd4));
        vecs.push_back(mk(0, 0, 8'h48, 8'h08, 1, 3'd3, 4'd4, 8'h48, 1, 3'd3, 4'd4));
        // Test 4: in[7] at t=1, in[3]+in[1] at t=3; K=2 then inhibits.
        vecs.push_back(zr(0, 1, 8'h48));
        vecs.push_back(zr(0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h80, 8'h80, 1, 3'd7, 4'd1, 8'h80, 1, 3'd7, 4'd1));
        vecs.push_back(mk(0, 0, 8'h80, 8'h80, 1, 3'd7, 4'd1, 8'h80, 1, 3'd7, 4'd1));
        vecs.push_back(mk(0, 0, 8'h8A, 8'h80, 1, 3'd7, 4'd1, 8'h82, 1, 3'd7, 4'd1));
        vecs.push_back(mk(0, 0, 8'h8A, 8'h80, 1, 3'd7, 4'd1, 8'h82, 1, 3'd7, 4'd1));
        vecs.push_back(mk(0, 0, 8'h80, 8'h80, 1, 3'd7, 4'd1, 8'h82, 1, 3'd7, 4'd1));
        vecs.push_back(mk(0, 0, 8'h88, 8'h80, 1, 3'd7, 4'd1, 8'h82, 1, 3'd7, 4'd1));
        // Test 5: edge in the grst cycle is discarded; re-raise at t=6 wins.
        vecs.push_back(zr(0, 1, 8'h01));
        for (int n = 0; n < 4; n++) vecs.push_back(zr(0, 0, 8'h01));
        vecs.push_back(zr(0, 0, 8'h00));
        vecs.push_back(zr(0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h01, 8'h01, 1, 3'd0, 4'd6, 8'h01, 1, 3'd0, 4'd6));
        vecs.push_back(mk(0, 0, 8'h01, 8'h01, 1, 3'd0, 4'd6, 8'h01, 1, 3'd0, 4'd6));
        // Test 6: rst at t=8 clears, later edges ignored until grst; rst beats grst.
        vecs.push_back(zr(1, 0, 8'h01));
        vecs.push_back(zr(0, 0, 8'h10));
        vecs.push_back(zr(0, 0, 8'h30));
        vecs.push_back(zr(1, 1, 8'h00));
        vecs.push_back(zr(0, 0, 8'h00));
        vecs.push_back(zr(0, 0, 8'h40));

        for (int r = 0; r < vecs.size(); r++) begin
            rst = vecs[r].rst; grst = vecs[r].grst; in_v = vecs[r].in;
            tick();
            chk_all($sformatf("row%0d", r),
                    vecs[r].o1, vecs[r].v1, vecs[r].i1, vecs[r].t1,
                    vecs[r].o2, vecs[r].v2, vecs[r].i2, vecs[r].t2);
        end

        // Idle gamma cycle: tcnt saturates at 15 and a late spike reports time 15.
        rst = 1'b0; grst = 1'b1; in_v = 8'h00; tick();
        grst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (n % 5 == 4)
                chk_all("idle", 8'h00, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0, 3'd0, 4'd0);
        end
        in_v = 8'h10; tick();
        chk_all("sat", 8'h10, 1'b1, 3'd4, 4'd15, 8'h10, 1'b1, 3'd4, 4'd15);
        in_v = 8'h30; tick();
        chk_all("sat2", 8'h10, 1'b1, 3'd4, 4'd15, 8'h30, 1'b1, 3'd4, 4'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
